// File: rtl/spi_master_arbiter_if.sv
// Requester-side and MASTER-side handshake bundle for spi_master_arbiter.
interface spi_master_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   ack;
    logic [7:0]         rx_data;
    logic               err;
    logic               busy;
    logic               transmit;
    logic               d_valid;
    logic [7:0]         data_M;
    logic               done_M;
    logic [7:0]         rx_M;

    modport master (
        output req, req_data, done_M, rx_M,
        input  gnt, ack, rx_data, err, busy,
        input  transmit, d_valid, data_M
    );

    modport slave (
        input  req, req_data, done_M, rx_M,
        output gnt, ack, rx_data, err, busy,
        output transmit, d_valid, data_M
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one SPI MASTER byte engine among N_REQ requesters,
// with an inter-transfer gap and a per-transfer hang timeout.
module spi_master_arbiter #(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1023
) (
    input logic                 CLK_M,
    input logic                 reset_n,
    spi_master_arbiter_if.slave bus
);
    localparam int LW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, XFER, RELEASE, GAP} state_t;

    state_t           state, state_n;
    logic [LW-1:0]    last, last_n;
    logic [15:0]      tcnt, tcnt_n;
    logic [7:0]       gcnt, gcnt_n;
    logic [N_REQ-1:0] gnt, gnt_n;
    logic [N_REQ-1:0] ack, ack_n;
    logic [7:0]       rx_data, rx_data_n;
    logic [7:0]       data_m, data_m_n;
    logic             err, err_n;
    logic             busy, busy_n;
    logic             transmit, transmit_n;
    logic             d_valid, d_valid_n;

    logic             found;
    logic [LW-1:0]    win;
    logic [7:0]       win_data;

    // First set request searching upward from last+1, wrapping.
    always_comb begin : arb
        int idx;
        found    = 1'b0;
        win      = '0;
        win_data = '0;
        idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!found && bus.req[idx]) begin
                found    = 1'b1;
                win      = LW'(idx);
                win_data = bus.req_data[8*idx +: 8];
            end
        end
    end

    always_comb begin
        state_n    = state;
        last_n     = last;
        tcnt_n     = tcnt;
        gcnt_n     = gcnt;
        gnt_n      = gnt;
        ack_n      = '0;
        err_n      = 1'b0;
        rx_data_n  = rx_data;
        data_m_n   = data_m;
        transmit_n = transmit;
        d_valid_n  = d_valid;
        unique case (state)
            IDLE: begin
                if (found) begin
                    gnt_n      = '0;
                    gnt_n[win] = 1'b1;
                    transmit_n = 1'b1;
                    d_valid_n  = 1'b1;
                    data_m_n   = win_data;
                    last_n     = win;
                    tcnt_n     = '0;
                    state_n    = XFER;
                end
            end
            XFER: begin
                tcnt_n = tcnt + 16'd1;
                if (bus.done_M) begin
                    rx_data_n  = bus.rx_M;
                    ack_n      = gnt;
                    gnt_n      = '0;
                    transmit_n = 1'b0;
                    d_valid_n  = 1'b0;
                    state_n    = RELEASE;
                end else if ((17'(tcnt) + 17'd1) == 17'(TIMEOUT)) begin
                    rx_data_n  = 8'h00;
                    ack_n      = gnt;
                    err_n      = 1'b1;
                    gnt_n      = '0;
                    transmit_n = 1'b0;
                    d_valid_n  = 1'b0;
                    state_n    = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus.done_M) begin
                    if (GAP_CYCLES == 0) begin
                        state_n = IDLE;
                    end else begin
                        gcnt_n  = 8'(GAP_CYCLES);
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                gcnt_n = gcnt - 8'd1;
                if (gcnt <= 8'd1) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge CLK_M) begin
        if (!reset_n) begin
            state    <= IDLE;
            last     <= LW'(N_REQ - 1);
            tcnt     <= '0;
            gcnt     <= '0;
            gnt      <= '0;
            ack      <= '0;
            rx_data  <= '0;
            data_m   <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            transmit <= 1'b0;
            d_valid  <= 1'b0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            tcnt     <= tcnt_n;
            gcnt     <= gcnt_n;
            gnt      <= gnt_n;
            ack      <= ack_n;
            rx_data  <= rx_data_n;
            data_m   <= data_m_n;
            err      <= err_n;
            busy     <= busy_n;
            transmit <= transmit_n;
            d_valid  <= d_valid_n;
        end
    end

    assign bus.gnt      = gnt;
    assign bus.ack      = ack;
    assign bus.rx_data  = rx_data;
    assign bus.err      = err;
    assign bus.busy     = busy;
    assign bus.transmit = transmit;
    assign bus.d_valid  = d_valid;
    assign bus.data_M   = data_m;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: vector table, hand sequences and random
// transfers checked against a transaction-level round-robin model.
module tb_spi_master_arbiter;
    localparam int N  = 4;
    localparam int G  = 4;
    localparam int TO = 20;

    logic CLK_M   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   tests   = 0;
    int   fails   = 0;
    int   m_last  = N - 1;
    int   prev_ok = 0;
    int   prev_t  = 0;
    int   prev_rel = 0;

    spi_master_arbiter_if #(.N_REQ(N)) bus ();
    spi_master_arbiter_if #(.N_REQ(4)) bus2 ();

    spi_master_arbiter #(.N_REQ(N), .GAP_CYCLES(G), .TIMEOUT(TO)) dut (
        .CLK_M(CLK_M), .reset_n(reset_n), .bus(bus)
    );

    spi_master_arbiter dut2 (
        .CLK_M(CLK_M), .reset_n(reset_n), .bus(bus2)
    );

    always #5 CLK_M = ~CLK_M;
    always @(posedge CLK_M) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          dly;
        int          hold;
        logic [7:0]  rx;
        int          w;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(negedge CLK_M);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [3:0] r);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, bus.gnt, 0);
        chk({tag, "_ack"}, bus.ack, 0);
        chk({tag, "_rx_data"}, bus.rx_data, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_transmit"}, bus.transmit, 0);
        chk({tag, "_d_valid"}, bus.d_valid, 0);
        chk({tag, "_data_M"}, bus.data_M, 0);
    endtask

    // One complete transfer: present requests, await grant, play MASTER.
    task automatic do_xfer(input logic [3:0] req, input logic [31:0] data,
                           input int dly, input int hold,
                           input logic [7:0] rx, input int w);
        int         t_req, k, bad;
        logic       e;
        logic [3:0] expg;
        logic [7:0] byt;
        expg = 4'(1 << w);
        byt  = data[8*w +: 8];
        e    = (dly > TO);
        bus.req      = req;
        bus.req_data = data;
        bus.rx_M     = 8'($urandom_range(1, 255));
        t_req = cyc;
        k = 0;
        bad = 0;
        while (bus.gnt == 0 && k < 100) begin
            tick();
            k++;
            if (bus.ack !== 0 || bus.err !== 0) bad++;
        end
        if (bus.gnt == 0) begin
            tests++;
            fails++;
            $display("FAIL gnt_wait: no grant within 100 cycles, need %0h", expg);
            return;
        end
        chk("gnt", bus.gnt, expg);
        chk("data_M", bus.data_M, byt);
        chk("transmit_on", bus.transmit, 1);
        chk("d_valid_on", bus.d_valid, 1);
        chk("busy_on", bus.busy, 1);
        chk("ack_quiet", bad, 0);
        if (prev_ok != 0) chk("spacing", cyc - prev_t, prev_rel + G + 1);
        else chk("req_to_gnt", cyc - t_req, 1);
        m_last = w;
        k = 0;
        bad = 0;
        while (bus.ack == 0 && k < 200) begin
            k++;
            if (!e && k == dly) begin
                bus.done_M = 1'b1;
                bus.rx_M   = rx;
            end
            tick();
            if (bus.ack == 0 && (bus.gnt !== expg || bus.transmit !== 1'b1
                                 || bus.data_M !== byt)) bad++;
        end
        chk("ack_lat", k, e ? TO : dly);
        chk("ack", bus.ack, expg);
        chk("err", bus.err, e);
        chk("rx_data", bus.rx_data, e ? 8'h00 : rx);
        chk("gnt_off", bus.gnt, 0);
        chk("transmit_off", bus.transmit, 0);
        chk("d_valid_off", bus.d_valid, 0);
        chk("xfer_stable", bad, 0);
        prev_t = cyc;
        bad = 0;
        for (int j = 1; j < hold && !e; j++) begin
            tick();
            if (bus.ack !== 0 || bus.busy !== 1'b1) bad++;
        end
        chk("single_ack", bad, 0);
        bus.done_M = 1'b0;
        bus.rx_M   = 8'($urandom_range(1, 255));
        prev_rel = e ? 1 : hold;
        prev_ok  = 1;
    endtask

    initial begin
        vecs[0]  = '{4'hF, 32'h43322110, 5, 1, 8'h5A, 0};
        vecs[1]  = '{4'hF, 32'h43322110, 3, 1, 8'h11, 1};
        vecs[2]  = '{4'hF, 32'h43322110, 20, 1, 8'h77, 2};
        vecs[3]  = '{4'hF, 32'h43322110, 1, 1, 8'h3C, 3};
        vecs[4]  = '{4'hF, 32'h43322110, 7, 2, 8'h99, 0};
        vecs[5]  = '{4'hF, 32'h43322110, 4, 1, 8'h12, 1};
        vecs[6]  = '{4'hF, 32'h43322110, 6, 1, 8'h34, 2};
        vecs[7]  = '{4'h5, 32'h43322110, 8, 1, 8'h56, 0};
        vecs[8]  = '{4'h5, 32'h43322110, 2, 1, 8'h78, 2};
        vecs[9]  = '{4'h1, 32'h433221B3, 12, 1, 8'hCA, 0};
        vecs[10] = '{4'h4, 32'h43322110, 25, 1, 8'hEE, 2};
        vecs[11] = '{4'h8, 32'h43322110, 4, 1, 8'h21, 3};
        vecs[12] = '{4'h2, 32'h43322110, 3, 10, 8'h65, 1};
        vecs[13] = '{4'h4, 32'h43322110, 21, 1, 8'hAB, 2};
        vecs[14] = '{4'h1, 32'h43322110, 2, 1, 8'hCD, 0};

        bus.req = '0;  bus.req_data = '0;  bus.done_M = 1'b0;  bus.rx_M = '0;
        bus2.req = '0; bus2.req_data = '0; bus2.done_M = 1'b0; bus2.rx_M = '0;
        reset_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;

        // Default parameters: 80-cycle MASTER latency must not time out.
        bus2.req      = 4'b0001;
        bus2.req_data = 32'h000000B3;
        tick();
        chk("single_gnt", bus2.gnt, 4'b0001);
        chk("single_data_M", bus2.data_M, 8'hB3);
        chk("single_transmit", bus2.transmit, 1);
        repeat (79) tick();
        chk("single_no_early_ack", bus2.ack, 0);
        bus2.done_M = 1'b1;
        bus2.rx_M   = 8'hCA;
        tick();
        chk("single_ack", bus2.ack, 4'b0001);
        chk("single_rx", bus2.rx_data, 8'hCA);
        chk("single_err", bus2.err, 0);
        chk("single_transmit_off", bus2.transmit, 0);
        bus2.done_M = 1'b0;
        bus2.req    = '0;
        tick();
        chk("single_ack_pulse", bus2.ack, 0);

        foreach (vecs[i])
            do_xfer(vecs[i].req, vecs[i].data, vecs[i].dly, vecs[i].hold,
                    vecs[i].rx, vecs[i].w);

        // Reset in the middle of a transfer.
        bus.req      = 4'hF;
        bus.req_data = 32'h43322110;
        for (int k = 0; k < 100 && bus.gnt == 0; k++) tick();
        repeat (3) tick();
        chk("mid_busy", bus.busy, 1);
        reset_n = 1'b0;
        tick();
        check_all_zero("mid_reset");
        reset_n  = 1'b1;
        m_last   = N - 1;
        prev_ok  = 0;
        do_xfer(4'hF, 32'h43322110, 5, 1, 8'h42, 0);

        for (int n = 0; n < 40; n++) begin
            logic [3:0]  r;
            logic [31:0] d;
            r = 4'($urandom_range(1, 15));
            d = $urandom;
            do_xfer(r, d, $urandom_range(1, 24), $urandom_range(1, 3),
                    8'($urandom), model_pick(r));
        end

        bus.req = '0;
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Round-robin arbiter and sequencer that shares one SPI `MASTER` byte engine among `N_REQ` on-chip requesters. It grants one requester at a time and drives the master's `transmit` / `d_valid` / `data_M` handshake. When `done_M` arrives it returns the received byte `rx_M` to the granted requester. It sits between the requester-side logic and the `MASTER` instance, in the `CLK_M` domain. It enforces an inter-transfer gap and a hang timeout.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `GAP_CYCLES`, default 4: idle `CLK_M` cycles between the release of one transfer and the next grant, 0..255.
- `TIMEOUT`, default 1023: maximum `XFER` cycles before aborting, 1..65535.

Ports:
- `CLK_M`  in  1  single clock; all logic on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req`  in  N_REQ  per-requester transfer request; level, held until `ack`.
- `req_data`  in  8*N_REQ  byte to send; requester i uses bits [8i+7:8i]; held until `ack`.
- `gnt`  out  N_REQ  one-hot grant, high for the whole transfer.
- `ack`  out  N_REQ  one-cycle completion pulse to the granted requester.
- `rx_data`  out  8  byte received by the last transfer; valid from the `ack` cycle until the next `ack`.
- `err`  out  1  high together with `ack` when the transfer timed out.
- `busy`  out  1  high whenever state ≠ `IDLE`.
- `transmit`  out  1  to MASTER: transfer enable.
- `d_valid`  out  1  to MASTER: `data_M` valid.
- `data_M`  out  8  to MASTER: byte to shift out.
- `done_M`  in  1  from MASTER: byte complete; may stay high for several cycles.
- `rx_M`  in  8  from MASTER: received byte, valid while `done_M` = 1.

## Operation
- Reset (`reset_n` = 0 at an edge):
  - state goes to `IDLE`.
  - All outputs go to 0: `gnt`, `ack`, `rx_data`, `err`, `busy`, `transmit`, `d_valid`, `data_M`.
  - Timeout and gap counters clear.
  - The round-robin pointer `last` is set to `N_REQ-1`, so requester 0 has first priority.
  - Reset during any state aborts the transfer immediately: `transmit` drops and no `ack` is issued.
- States:
  - `IDLE`: if any `req` bit is high, choose the winner w by the first set bit searching from `last+1` upward, modulo `N_REQ`. At the next edge:
    - `gnt[w]`, `transmit` and `d_valid` go to 1.
    - `data_M` takes `req_data[w]`; `last` takes w.
    - The timeout counter clears and state goes to `XFER`.
  - `XFER`: hold `gnt`, `transmit`, `d_valid` and `data_M` stable; the timeout counter increments each cycle.
    - If `done_M` = 1 at an edge: `rx_data` takes `rx_M`, `ack[w]` goes to 1, `err` goes to 0, and `gnt`, `transmit` and `d_valid` go to 0. State goes to `RELEASE`.
    - Otherwise, if the counter equals `TIMEOUT`: the same actions, except `rx_data` takes 0x00 and `err` goes to 1.
    - `done_M` has priority over timeout when both occur on the same edge.
  - `RELEASE`: `ack` and `err` return to 0 after one cycle. Wait for `done_M` = 0.
    - Then load the gap counter with `GAP_CYCLES` and go to `GAP`.
    - If `GAP_CYCLES` = 0, go directly to `IDLE`.
  - `GAP`: decrement the counter; when it reaches 0, go to `IDLE`.
- Requester behaviour:
  - Dropping `req` during `XFER` does not cancel the transfer; `ack` is still issued.
  - A `req` still high after its `ack` is treated as a new request and is arbitrated normally.
- `data_M` keeps its last value when idle; the MASTER ignores it while `d_valid` = 0.

## Timing
- Request to `gnt` / `transmit`: 1 cycle from the `IDLE` edge that samples `req`.
- First edge with `done_M` = 1 to `ack`: 1 cycle.
- Minimum spacing from one `ack` to the next `gnt`: 1 (`RELEASE`, if `done_M` is already low) + `GAP_CYCLES` + 1 (`IDLE`) cycles.
- `busy` is registered and goes high on the same edge as `gnt`.
- Every output is a register output; there are no combinational paths from inputs to outputs.

## Test plan
- Single request:
  - Stimulus: `req` = 0001, `req_data[7:0]` = 0xB3; the MASTER model returns `rx_M` = 0xCA with `done_M` after 80 cycles.
  - Response: `gnt` = 0001 and `data_M` = 0xB3 one cycle after `req`; `ack` = 0001 with `rx_data` = 0xCA one cycle after `done_M`; `err` = 0.
- Round robin:
  - Stimulus: `req` = 1111 held, with `req_data` bytes 0x10, 0x21, 0x32, 0x43 for requesters 0..3.
  - Response: grant order 0,1,2,3,0; each `gnt` edge is separated from the previous `ack` by ≥ `GAP_CYCLES` + 2 cycles.
- Skipping idle requesters:
  - Stimulus: after requester 2 is served, `req` = 0101.
  - Response: next grant goes to requester 0 (wrap-around), then to requester 2.
- Timeout:
  - Stimulus: `TIMEOUT` = 20, `done_M` never asserted.
  - Response: after 20 `XFER` cycles, `ack` pulses with `err` = 1 and `rx_data` = 0x00, `transmit` = 0, and the next request proceeds normally.
- Long `done_M`:
  - Stimulus: `done_M` held high for 10 cycles.
  - Response: exactly one `ack`; the FSM stays in `RELEASE` until `done_M` = 0, then the gap runs.
- Reset mid-transfer:
  - Stimulus: `reset_n` = 0 for one edge during `XFER`.
  - Response: all outputs are 0 at the next edge and no `ack` is issued; after release, requester 0 wins with `req` = 1111.
